// File: rtl/bitstream_uart_tx.sv
// Serialises 32-bit configuration words onto a UART line as four 8N1 bytes.
// Tx, word_ready and word_done are all registered; reset is asynchronous and active high.
module bitstream_uart_tx #(
   parameter int unsigned CLKS_PER_BIT    = 104,
   parameter int unsigned MSB_FIRST_BYTES = 1
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [31:0] word_data,
   input  logic        word_valid,
   output logic        word_ready,
   output logic        Tx,
   output logic        busy,
   output logic        word_done,
   output logic [15:0] word_count
);

   if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : gen_param_check
      $error("CLKS_PER_BIT must be in 2..65535");
   end

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   localparam logic [15:0] BitReload = 16'(CLKS_PER_BIT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [31:0] word_q, word_d;
   logic        tx_q, tx_d;
   logic        word_ready_q, word_ready_d;
   logic        word_done_q, word_done_d;
   logic [15:0] word_count_q, word_count_d;
   logic        bit_end;
   logic [1:0]  byte_sel;
   logic [7:0]  cur_byte;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 16'd0;
         bit_idx_q    <= 3'd0;
         byte_idx_q   <= 2'd0;
         word_q       <= 32'd0;
         tx_q         <= 1'b1;
         word_ready_q <= 1'b1;
         word_done_q  <= 1'b0;
         word_count_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_idx_q    <= bit_idx_d;
         byte_idx_q   <= byte_idx_d;
         word_q       <= word_d;
         tx_q         <= tx_d;
         word_ready_q <= word_ready_d;
         word_done_q  <= word_done_d;
         word_count_q <= word_count_d;
      end
   end

   // cnt_q counts down the remaining cycles of the current bit; zero marks its last cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      word_d     = word_q;
      bit_end    = (cnt_q == 16'd0);
      case (state_q)
         StIdle: begin
            if (word_valid && word_ready_q) begin
               state_d    = StStart;
               cnt_d      = BitReload;
               word_d     = word_data;
               bit_idx_d  = 3'd0;
               byte_idx_d = 2'd0;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d   = StData;
               cnt_d     = BitReload;
               bit_idx_d = 3'd0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = BitReload;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         StStop: begin
            if (bit_end) begin
               if (byte_idx_q == 2'd3) begin
                  state_d = StIdle;
               end else begin
                  state_d    = StStart;
                  cnt_d      = BitReload;
                  byte_idx_d = byte_idx_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are computed from the next state so that they land in registers on the same edge.
   always_comb begin
      byte_sel = (MSB_FIRST_BYTES != 0) ? ~byte_idx_d : byte_idx_d;
      cur_byte = word_d[{byte_sel, 3'b000} +: 8];
      tx_d     = 1'b1;
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = cur_byte[bit_idx_d];
         default: tx_d = 1'b1;
      endcase
      word_ready_d = (state_d == StIdle);
      word_done_d  = (state_q == StStop) && (state_d == StIdle);
      word_count_d = word_count_q + {15'd0, word_done_d};
   end

   assign Tx         = tx_q;
   assign word_ready = word_ready_q;
   assign busy       = ~word_ready_q;
   assign word_done  = word_done_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_bitstream_uart_tx.sv
// Directed bench for bitstream_uart_tx: four instances cover MSB/LSB byte order and
// bit periods of 2, 4 and 104 clocks.
module tb_bitstream_uart_tx;

   logic        CLK;
   logic        reset;
   logic [31:0] wd   [4];
   logic        wv   [4];
   logic        rdy  [4];
   logic        tx   [4];
   logic        bsy  [4];
   logic        done [4];
   logic [15:0] cnt  [4];

   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   bitstream_uart_tx #(.CLKS_PER_BIT(4), .MSB_FIRST_BYTES(1)) u_d4m (
      .CLK(CLK), .reset(reset), .word_data(wd[0]), .word_valid(wv[0]), .word_ready(rdy[0]),
      .Tx(tx[0]), .busy(bsy[0]), .word_done(done[0]), .word_count(cnt[0]));

   bitstream_uart_tx #(.CLKS_PER_BIT(4), .MSB_FIRST_BYTES(0)) u_d4l (
      .CLK(CLK), .reset(reset), .word_data(wd[1]), .word_valid(wv[1]), .word_ready(rdy[1]),
      .Tx(tx[1]), .busy(bsy[1]), .word_done(done[1]), .word_count(cnt[1]));

   bitstream_uart_tx #(.CLKS_PER_BIT(2), .MSB_FIRST_BYTES(1)) u_d2 (
      .CLK(CLK), .reset(reset), .word_data(wd[2]), .word_valid(wv[2]), .word_ready(rdy[2]),
      .Tx(tx[2]), .busy(bsy[2]), .word_done(done[2]), .word_count(cnt[2]));

   bitstream_uart_tx #(.CLKS_PER_BIT(104), .MSB_FIRST_BYTES(1)) u_d104 (
      .CLK(CLK), .reset(reset), .word_data(wd[3]), .word_valid(wv[3]), .word_ready(rdy[3]),
      .Tx(tx[3]), .busy(bsy[3]), .word_done(done[3]), .word_count(cnt[3]));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) wv[i] = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
   endtask

   // Presents a word at a negedge; returns just after the accepting posedge.
   task automatic start_word(input int idx, input logic [31:0] w);
      @(negedge CLK);
      wd[idx] = w;
      wv[idx] = 1'b1;
      @(posedge CLK);
      #1 wv[idx] = 1'b0;
   endtask

   // Samples 40 bit periods at every negedge, then one more cycle (the word_done cycle).
   task automatic collect(input int idx, input int n, output logic [39:0] line,
                          output int unstable, output int bad_status,
                          output logic done_end, output logic [15:0] cnt_end);
      logic first;
      unstable   = 0;
      bad_status = 0;
      first      = 1'b0;
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < n; j++) begin
            @(negedge CLK);
            if (j == 0) first = tx[idx];
            else if (tx[idx] !== first) unstable++;
            if (done[idx] !== 1'b0 || rdy[idx] !== 1'b0 || bsy[idx] !== 1'b1) bad_status++;
         end
         line[k] = first;
      end
      @(negedge CLK);
      done_end = done[idx];
      cnt_end  = cnt[idx];
   endtask

   function automatic logic [31:0] bytes_of(input logic [39:0] line);
      return {line[8:1], line[18:11], line[28:21], line[38:31]};
   endfunction

   function automatic logic [7:0] framing_of(input logic [39:0] line);
      return {line[39], line[29], line[19], line[9], line[30], line[20], line[10], line[0]};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wv[i] = 1'b0;
         wd[i] = 32'd0;
      end
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (tx[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || done[i] !== 1'b0 ||
             cnt[i] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset[%0d]: tx=%b rdy=%b busy=%b done=%b cnt=%h, need 1 1 0 0 0000",
                     i, tx[i], rdy[i], bsy[i], done[i], cnt[i]);
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_idle();
      int bad;
      bad = 0;
      do_reset();
      repeat (40) begin
         @(negedge CLK);
         if (tx[0] !== 1'b1 || rdy[0] !== 1'b1 || done[0] !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL idle: %0d cycles with Tx/ready/done disturbed, need 0", bad);
      end
   endtask

   task automatic test_msb_first();
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      start_word(0, 32'hFAB0_1234);
      collect(0, 4, line, unst, bad, de, ce);
      n_tests++;
      if (bytes_of(line) !== 32'hFAB0_1234) begin
         n_fail++;
         $display("FAIL msb_bytes: got %h, need fab01234", bytes_of(line));
      end
      n_tests++;
      if (line[9:0] !== 10'b11_1111_0100) begin
         n_fail++;
         $display("FAIL msb_byte0_line: got %b (bit0 right), need 1111110100", line[9:0]);
      end
      n_tests++;
      if (framing_of(line) !== 8'hF0 || unst !== 0 || bad !== 0) begin
         n_fail++;
         $display("FAIL msb_framing: frame=%h unstable=%0d status=%0d, need f0 0 0",
                  framing_of(line), unst, bad);
      end
      n_tests++;
      if (de !== 1'b1 || ce !== 16'd1) begin
         n_fail++;
         $display("FAIL msb_done_161: done=%b count=%h, need 1 0001", de, ce);
      end
      @(negedge CLK);
      n_tests++;
      if (done[0] !== 1'b0 || rdy[0] !== 1'b1 || tx[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL msb_after: done=%b rdy=%b tx=%b, need 0 1 1", done[0], rdy[0], tx[0]);
      end
   endtask

   task automatic test_lsb_first();
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      start_word(1, 32'h0000_00FF);
      collect(1, 4, line, unst, bad, de, ce);
      n_tests++;
      if (bytes_of(line) !== 32'hFF00_0000 || framing_of(line) !== 8'hF0) begin
         n_fail++;
         $display("FAIL lsb_bytes: got %h frame %h, need ff000000 f0",
                  bytes_of(line), framing_of(line));
      end
      n_tests++;
      if (de !== 1'b1 || ce !== 16'd1 || unst !== 0) begin
         n_fail++;
         $display("FAIL lsb_done: done=%b count=%h unstable=%0d, need 1 0001 0", de, ce, unst);
      end
   endtask

   task automatic test_back_to_back();
      logic pre [501];
      int   acc [3];
      int   nacc, ndone;
      do_reset();
      nacc  = 0;
      ndone = 0;
      for (int i = 0; i < 3; i++) acc[i] = -1;
      @(negedge CLK);
      wd[0] = 32'hC001_D00D;
      wv[0] = 1'b1;
      for (int e = 0; e <= 500; e++) begin
         pre[e] = tx[0];
         if (rdy[0] === 1'b1 && wv[0] === 1'b1 && nacc < 3) begin
            acc[nacc] = e;
            nacc++;
         end
         if (done[0] === 1'b1) ndone++;
         if (e == 500) break;
         @(posedge CLK);
         #1;
         if (nacc == 3) wv[0] = 1'b0;
         @(negedge CLK);
      end
      n_tests++;
      if (acc[0] !== 0 || acc[1] !== 161 || acc[2] !== 322) begin
         n_fail++;
         $display("FAIL b2b_accepts: got %0d %0d %0d, need 0 161 322", acc[0], acc[1], acc[2]);
      end
      n_tests++;
      if (pre[160] !== 1'b1 || pre[161] !== 1'b1 || pre[162] !== 1'b0 ||
          pre[322] !== 1'b1 || pre[323] !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gap: tx around boundaries %b%b%b %b%b, need 110 10",
                  pre[160], pre[161], pre[162], pre[322], pre[323]);
      end
      n_tests++;
      if (ndone !== 3 || cnt[0] !== 16'd3) begin
         n_fail++;
         $display("FAIL b2b_count: done pulses=%0d count=%h, need 3 0003", ndone, cnt[0]);
      end
   endtask

   task automatic test_ignore_busy();
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      start_word(0, 32'hA5C3_0F96);
      fork
         collect(0, 4, line, unst, bad, de, ce);
         begin
            repeat (48) @(posedge CLK);
            #1;
            wd[0] = 32'h1234_5678;
            wv[0] = 1'b1;
            @(posedge CLK);
            #1 wv[0] = 1'b0;
         end
      join
      n_tests++;
      if (bytes_of(line) !== 32'hA5C3_0F96 || framing_of(line) !== 8'hF0) begin
         n_fail++;
         $display("FAIL busy_ignore_bytes: got %h frame %h, need a5c30f96 f0",
                  bytes_of(line), framing_of(line));
      end
      n_tests++;
      if (bad !== 0 || de !== 1'b1 || ce !== 16'd1) begin
         n_fail++;
         $display("FAIL busy_ignore_ready: status=%0d done=%b count=%h, need 0 1 0001",
                  bad, de, ce);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      start_word(0, 32'h0000_0000);
      repeat (100) @(posedge CLK);
      #3;
      n_tests++;
      if (tx[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL midword_tx_before: got %b, need 0", tx[0]);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if (tx[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0 || cnt[0] !== 16'd0) begin
         n_fail++;
         $display("FAIL midword_reset: tx=%b rdy=%b busy=%b cnt=%h, need 1 1 0 0000",
                  tx[0], rdy[0], bsy[0], cnt[0]);
      end
      @(negedge CLK);
      reset = 1'b0;
      wd[0] = 32'h5A3C_81E7;
      wv[0] = 1'b1;
      @(posedge CLK);
      #1 wv[0] = 1'b0;
      collect(0, 4, line, unst, bad, de, ce);
      n_tests++;
      if (bytes_of(line) !== 32'h5A3C_81E7 || framing_of(line) !== 8'hF0) begin
         n_fail++;
         $display("FAIL midword_resend: got %h frame %h, need 5a3c81e7 f0",
                  bytes_of(line), framing_of(line));
      end
      n_tests++;
      if (de !== 1'b1 || ce !== 16'd1) begin
         n_fail++;
         $display("FAIL midword_count: done=%b count=%h, need 1 0001", de, ce);
      end
   endtask

   task automatic test_period(input int idx, input int n, input logic [31:0] w);
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      start_word(idx, w);
      collect(idx, n, line, unst, bad, de, ce);
      n_tests++;
      if (bytes_of(line) !== w || framing_of(line) !== 8'hF0 || unst !== 0) begin
         n_fail++;
         $display("FAIL period_%0d: got %h frame %h unstable=%0d, need %h f0 0",
                  n, bytes_of(line), framing_of(line), unst, w);
      end
      n_tests++;
      if (de !== 1'b1 || ce !== 16'd1 || bad !== 0) begin
         n_fail++;
         $display("FAIL period_%0d_done: done=%b count=%h status=%0d, need 1 0001 0",
                  n, de, ce, bad);
      end
   endtask

   task automatic test_count_wrap();
      logic [39:0] line;
      int          unst, bad;
      logic        de;
      logic [15:0] ce;
      do_reset();
      @(negedge CLK);
      force u_d2.word_count_q = 16'hFFFF;
      #1 release u_d2.word_count_q;
      #1;
      n_tests++;
      if (cnt[2] !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_preload: count=%h, need ffff", cnt[2]);
      end
      start_word(2, 32'h0F0F_F0F0);
      collect(2, 2, line, unst, bad, de, ce);
      n_tests++;
      if (de !== 1'b1 || ce !== 16'h0000 || bytes_of(line) !== 32'h0F0F_F0F0) begin
         n_fail++;
         $display("FAIL wrap: done=%b count=%h bytes=%h, need 1 0000 0f0ff0f0",
                  de, ce, bytes_of(line));
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_msb_first();
      test_lsb_first();
      test_back_to_back();
      test_ignore_busy();
      test_reset_mid_word();
      test_period(2, 2, 32'h8001_7EC3);
      test_period(3, 104, 32'h3CA5_00FF);
      test_count_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bitstream_uart_tx.md
BITSTREAM_UART_TX -- requirements
Module: bitstream_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 104, meaning CLK cycles per UART bit period (12 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter MSB_FIRST_BYTES, default 1, meaning byte order within a word: 1 sends bits [31:24] first, 0 sends bits [7:0] first.
REQ-003 The block SHALL have port CLK, input, width 1: the single system clock; all logic is rising-edge triggered.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port word_data, input, width 32: the configuration bitstream word to transmit.
REQ-006 The block SHALL have port word_valid, input, width 1: word_data is valid.
REQ-007 The block SHALL have port word_ready, output, width 1: the block can accept a word.
REQ-008 The block SHALL have port Tx, output, width 1: the serial line driven into the fabric config port Rx; idle high.
REQ-009 The block SHALL have port busy, output, width 1: high while a word is being serialised.
REQ-010 The block SHALL have port word_done, output, width 1: one-cycle pulse when the final stop bit of a word completes.
REQ-011 The block SHALL have port word_count, output, width 16: the number of words fully transmitted since reset; it wraps from 0xFFFF to 0x0000.

Function
REQ-012 The block SHALL accept a word in exactly the cycle where word_valid=1 and word_ready=1, latching word_data into an internal 32-bit register.
REQ-013 word_ready SHALL equal 1 only in state IDLE, and it SHALL be registered (no combinational path from word_valid).
REQ-014 The state machine SHALL have states IDLE, START, DATA, and STOP.
  - IDLE->START on accept.
  - START->DATA after CLKS_PER_BIT cycles.
  - DATA->STOP after 8 bits.
  - STOP->START when the byte index is below 3; STOP->IDLE when the byte index is 3.
REQ-015 Tx SHALL be registered and SHALL have the following values:
  - 1 in IDLE and STOP;
  - 0 in START;
  - the current data bit in DATA.
REQ-016 Within each byte, bits SHALL be sent LSB first (standard 8N1), with one start bit and one stop bit, no parity.
REQ-017 Every bit, including start and stop, SHALL hold Tx stable for exactly CLKS_PER_BIT cycles, timed by a 16-bit down-counter reloaded at each bit boundary.
REQ-018 Tx SHALL fall to 0 in the first cycle after the accept cycle.
REQ-019 One word SHALL occupy exactly 40*CLKS_PER_BIT cycles of Tx activity.
REQ-020 When word_valid is held high continuously, consecutive words SHALL be separated by exactly one extra idle-high cycle (the accept cycle) after the stop bit.
REQ-021 word_done SHALL pulse in the first IDLE cycle after the final stop bit, and in the same cycle word_count SHALL increment by 1.
REQ-022 busy SHALL equal the inverse of word_ready.
REQ-023 word_data and word_valid changes SHALL have no effect while busy=1; the latched word alone is transmitted.
REQ-024 word_valid=0 in IDLE SHALL leave Tx=1 indefinitely, with no spurious start bits.
REQ-025 If CLKS_PER_BIT is below 2, elaboration SHALL fail.

Reset
REQ-026 While reset=1, regardless of CLK, the block SHALL hold these values:
  - state=IDLE;
  - Tx=1;
  - word_ready=1;
  - busy=0;
  - word_done=0;
  - word_count=0;
  - the bit counter, byte index, and cycle counter all cleared.
REQ-027 Reset asserted mid-word SHALL abort the word immediately, drive Tx=1 in that same instant, and not increment word_count; the aborted word is never resumed.
REQ-028 After reset deasserts, the first accept SHALL be possible on the first rising CLK edge.

Verification
REQ-029 With CLKS_PER_BIT=4, MSB_FIRST_BYTES=1, send 0xFAB0_1234 and sample mid-bit. Required response:
  - Tx bytes decode as 0xFA, 0xB0, 0x12, 0x34;
  - Tx line for byte 0 is 0,0,1,0,1,1,1,1,1,1;
  - word_done pulses at cycle 161 after accept;
  - word_count=1.
REQ-030 With CLKS_PER_BIT=4, MSB_FIRST_BYTES=0, send 0x0000_00FF. Required response: the first byte decoded is 0xFF and the remaining three bytes are 0x00.
REQ-031 With word_valid held high and 3 words queued, required response:
  - accepts occur at cycles 0, 161, and 322;
  - exactly 1 idle-high cycle occurs between the stop bit and the next start bit;
  - word_count=3.
REQ-032 Change word_data and pulse word_valid during DATA of byte 1. Required response: the transmitted bytes are unchanged and word_ready stays 0.
REQ-033 Assert reset asynchronously mid-byte 2 (between clock edges). Required response:
  - Tx=1 immediately;
  - word_ready=1 and word_count=0;
  - a new word afterwards transmits correctly from its start bit.
REQ-034 Run with CLKS_PER_BIT=2 and with CLKS_PER_BIT=104, and wrap word_count by forcing 65536 words (or by preloading in a fast test). Required response: each bit lasts exactly N cycles, and word_count wraps to 0x0000.
